// File: rtl/dual_port_ram.sv
`default_nettype none
// ============================================================================
// dual_port_ram : simple dual-port RAM, write-only port A, read-only port B
//                 with a registered, write-first read path. Rev 1.0
// ============================================================================
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  rd_valid_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  collision;
  logic [DATA_WIDTH-1:0] read_data;

  // Storage is flop-based so the whole array can be cleared by the async reset.
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem[w] <= '0;
      end else if (wr_en_a && (addr_a == ADDR_WIDTH'(w))) begin
        mem[w] <= data_in_a;
      end
    end
  end

  // Same-address read and write on one edge returns the incoming data.
  always_comb begin
    collision = wr_en_a && (addr_a == addr_b);
    read_data = collision ? data_in_a : mem[addr_b];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_b <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_b <= rd_en_b;
      if (rd_en_b) begin
        data_out_b <= read_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram.sv
`default_nettype none
// ============================================================================
// tb_dual_port_ram : vector table, directed corner sequences and randomized
//                    traffic checked against an array-based reference. Rev 1.0
// ============================================================================
module tb_dual_port_ram;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_in_a;
  logic          rd_en_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_out_b;
  logic          rd_valid_b;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_a    (wr_en_a),
    .addr_a     (addr_a),
    .data_in_a  (data_in_a),
    .rd_en_b    (rd_en_b),
    .addr_b     (addr_b),
    .data_out_b (data_out_b),
    .rd_valid_b (rd_valid_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] aa;
    logic [DW-1:0] di;
    logic          rd;
    logic [AW-1:0] ab;
    logic [DW-1:0] exp_d;
    logic          exp_v;
  } vec_t;

  vec_t vecs[$];

  // Reference: memory contents plus the last read result seen at port B.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_d;
  logic          ref_v;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_d = '0;
    ref_v = 1'b0;
  endtask

  // Apply one cycle of stimulus, update the reference, sample 1 ns after the edge.
  task automatic step(input logic wr, input logic [AW-1:0] aa, input logic [DW-1:0] di,
                      input logic rd, input logic [AW-1:0] ab);
    @(negedge clk);
    wr_en_a = wr; addr_a = aa; data_in_a = di; rd_en_b = rd; addr_b = ab;
    @(posedge clk);
    if (rd) begin
      ref_d = (wr && aa == ab) ? di : ref_mem[ab];
      ref_v = 1'b1;
    end else begin
      ref_v = 1'b0;
    end
    if (wr) ref_mem[aa] = di;
    #1;
  endtask

  task automatic check_model(input string name);
    check({name, "_data"}, data_out_b, ref_d);
    check({name, "_valid"}, {{(DW-1){1'b0}}, rd_valid_b}, {{(DW-1){1'b0}}, ref_v});
  endtask

  initial begin
    rst = 1'b0;
    wr_en_a = 1'b0; addr_a = '0; data_in_a = '0; rd_en_b = 1'b0; addr_b = '0;
    model_reset();

    // Reset held with random enables: outputs must stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en_a = 1'($urandom); addr_a = AW'($urandom); data_in_a = DW'($urandom);
      rd_en_b = 1'b1; addr_b = AW'($urandom);
      @(posedge clk); #1;
      check("reset_data", data_out_b, '0);
      check("reset_valid", {{(DW-1){1'b0}}, rd_valid_b}, '0);
    end
    @(negedge clk);
    wr_en_a = 1'b0; rd_en_b = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, AW'(i));
      check("post_reset_read", data_out_b, '0);
    end

    // Fill/readback vector table.
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{wr: 1'b1, aa: AW'(i), di: DW'(i * 3), rd: 1'b0, ab: '0,
                       exp_d: '0, exp_v: 1'b0});
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{wr: 1'b0, aa: '0, di: '0, rd: 1'b1, ab: AW'(i),
                       exp_d: DW'(i * 3), exp_v: 1'b1});
    foreach (vecs[k]) begin
      step(vecs[k].wr, vecs[k].aa, vecs[k].di, vecs[k].rd, vecs[k].ab);
      check("table_data", data_out_b, vecs[k].exp_d);
      check("table_valid", {{(DW-1){1'b0}}, rd_valid_b}, {{(DW-1){1'b0}}, vecs[k].exp_v});
    end

    // Hold: last read returned 45 from addr 15.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, AW'(i + 3));
      check("hold_data", data_out_b, 8'd45);
      check("hold_valid", {{(DW-1){1'b0}}, rd_valid_b}, '0);
    end

    // Write-first collision.
    step(1'b1, 4'd5, 8'hAA, 1'b1, 4'd5);
    check("collision_data", data_out_b, 8'hAA);
    check("collision_valid", {{(DW-1){1'b0}}, rd_valid_b}, 8'd1);
    step(1'b0, '0, '0, 1'b1, 4'd5);
    check("collision_reread", data_out_b, 8'hAA);

    // Concurrent accesses to different addresses.
    step(1'b1, 4'd2, 8'h11, 1'b1, 4'd9);
    check("concurrent_read", data_out_b, 8'd27);
    step(1'b0, '0, '0, 1'b1, 4'd2);
    check("concurrent_reread", data_out_b, 8'h11);

    // Randomized traffic against the reference.
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a1, a2;
      a1 = AW'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom);
      step(1'($urandom), a1, DW'($urandom), 1'($urandom), a2);
      check_model("random");
    end

    // Mid-operation reset between a read edge and the next edge.
    step(1'b0, '0, '0, 1'b1, 4'd9);
    check("pre_abort_data", data_out_b, ref_mem[9]);
    #2 rst = 1'b0;
    #1;
    check("abort_data", data_out_b, '0);
    check("abort_valid", {{(DW-1){1'b0}}, rd_valid_b}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, AW'(i));
      check("abort_readback", data_out_b, '0);
      check_model("abort_model");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
